// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, latches the memory word into ir, and handles stall/jump/halt.
// Optional macro FETCH_BOUND_EN: a fetch at PC_LAST halts just like a HALT opcode does.
module fetch_unit #(
    parameter int unsigned            INSTRUCTION_WIDTH = 40,
    parameter int unsigned            PC_WIDTH          = 5,
    parameter logic [7:0]             HALT_OPCODE       = 8'hFF,
    parameter logic [PC_WIDTH-1:0]    PC_LAST           = 5'd31
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [PC_WIDTH-1:0]          pc,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    input  logic                         stall,
    input  logic                         jump_en,
    input  logic [PC_WIDTH-1:0]          jump_addr,
    output logic [INSTRUCTION_WIDTH-1:0] ir,
    output logic [PC_WIDTH-1:0]          ir_pc,
    output logic                         ir_valid,
    output logic                         halted,
    output logic [15:0]                  fetch_count
);

    // state | meaning
    // RUN   | fetching: jump > stall > normal fetch
    // HALT  | fetch stopped; only a jump (or reset) leaves
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

`ifdef FETCH_BOUND_EN
    localparam logic BOUND_EN = 1'b1;
`else
    localparam logic BOUND_EN = 1'b0;
`endif

    state_t                         state, state_nx;
    logic [PC_WIDTH-1:0]            pc_nx, ir_pc_nx;
    logic [INSTRUCTION_WIDTH-1:0]   ir_nx;
    logic                           ir_valid_nx, halted_nx, halt_hit;
    logic [15:0]                    fetch_count_nx;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        ir_nx          = ir;
        ir_pc_nx       = ir_pc;
        ir_valid_nx    = ir_valid;
        halted_nx      = halted;
        fetch_count_nx = fetch_count;
        halt_hit       = (instruction[INSTRUCTION_WIDTH-1 -: 8] == HALT_OPCODE) ||
                         (BOUND_EN && (pc == PC_LAST));
        case (state)
            RUN: begin
                halted_nx = 1'b0;
                if (jump_en) begin
                    pc_nx       = jump_addr;
                    ir_valid_nx = 1'b0;
                end else if (!stall) begin
                    ir_nx          = instruction;
                    ir_pc_nx       = pc;
                    ir_valid_nx    = 1'b1;
                    fetch_count_nx = (fetch_count == 16'hFFFF) ? fetch_count
                                                               : fetch_count + 16'd1;
                    // A halting word is still delivered; the PC just stops on it.
                    if (halt_hit) state_nx = HALT;
                    else          pc_nx    = pc + PC_WIDTH'(1);
                end
            end
            HALT: begin
                ir_valid_nx = 1'b0;
                if (jump_en) begin
                    pc_nx     = jump_addr;
                    halted_nx = 1'b0;
                    state_nx  = RUN;
                end else begin
                    halted_nx = 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            ir          <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc          <= pc_nx;
            ir          <= ir_nx;
            ir_pc       <= ir_pc_nx;
            ir_valid    <= ir_valid_nx;
            halted      <= halted_nx;
            fetch_count <= fetch_count_nx;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table plus hand sequences for wrap/bound, reset-in-halt and count saturation.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, jump_en;
    logic [4:0]  jump_addr, pc, ir_pc;
    logic [39:0] instruction, ir;
    logic        ir_valid, halted;
    logic [15:0] fetch_count;

    logic [39:0] mem [32];
    int n_chk = 0;
    int n_fail = 0;

    localparam logic [39:0] HW = 40'hFF_0000_0007;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
        .stall(stall), .jump_en(jump_en), .jump_addr(jump_addr),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted),
        .fetch_count(fetch_count)
    );

    assign instruction = mem[pc];

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, jen;
        logic [4:0]  jaddr;
        logic [4:0]  pc;
        logic [39:0] ir;
        logic [4:0]  ir_pc;
        logic        v, h;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic j, input logic [4:0] ja,
                       input logic [4:0] epc, input logic [39:0] eir, input logic [4:0] eirpc,
                       input logic ev, input logic eh, input logic [15:0] ecnt);
        vec_t t;
        t.rst = r; t.stall = s; t.jen = j; t.jaddr = ja;
        t.pc = epc; t.ir = eir; t.ir_pc = eirpc; t.v = ev; t.h = eh; t.cnt = ecnt;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] epc, input logic [39:0] eir,
                           input logic [4:0] eirpc, input logic ev, input logic eh,
                           input logic [15:0] ecnt);
        chk({tag, ".pc"},       40'(pc),          40'(epc));
        chk({tag, ".ir"},       ir,               eir);
        chk({tag, ".ir_pc"},    40'(ir_pc),       40'(eirpc));
        chk({tag, ".ir_valid"}, 40'(ir_valid),    40'(ev));
        chk({tag, ".halted"},   40'(halted),      40'(eh));
        chk({tag, ".count"},    40'(fetch_count), 40'(ecnt));
    endtask

    task automatic step(input logic r, input logic s, input logic j, input logic [4:0] ja);
        rst = r; stall = s; jump_en = j; jump_addr = ja;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 32; a++) mem[a] = 40'(a + 1);
        mem[6] = HW;
        rst = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = '0;

        //   rst stl jen addr |  pc  ir   ir_pc v  h  cnt
        add(1, 0, 0, 0,    0,  40'h0,  0, 0, 0, 0);
        add(0, 0, 0, 0,    1,  40'h1,  0, 1, 0, 1);
        add(0, 0, 0, 0,    2,  40'h2,  1, 1, 0, 2);
        add(0, 1, 0, 0,    2,  40'h2,  1, 1, 0, 2);
        add(0, 1, 0, 0,    2,  40'h2,  1, 1, 0, 2);
        add(0, 1, 0, 0,    2,  40'h2,  1, 1, 0, 2);
        add(0, 0, 0, 0,    3,  40'h3,  2, 1, 0, 3);
        add(0, 1, 1, 20,   20, 40'h3,  2, 0, 0, 3);
        add(0, 0, 0, 0,    21, 40'd21, 20, 1, 0, 4);
        add(0, 0, 1, 4,    4,  40'd21, 20, 0, 0, 4);
        add(0, 0, 0, 0,    5,  40'h5,  4, 1, 0, 5);
        add(0, 0, 0, 0,    6,  40'h6,  5, 1, 0, 6);
        add(0, 0, 0, 0,    6,  HW,     6, 1, 0, 7);
        for (int i = 0; i < 10; i++)
            add(0, logic'(i % 2), 0, 0, 6, HW, 6, 0, 1, 7);
        add(0, 0, 1, 0,    0,  HW,     6, 0, 0, 7);
        add(0, 0, 0, 0,    1,  40'h1,  0, 1, 0, 8);
        add(1, 1, 0, 0,    0,  40'h0,  0, 0, 0, 0);
        add(0, 0, 0, 0,    1,  40'h1,  0, 1, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].stall, tbl[i].jen, tbl[i].jaddr);
            chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ir, tbl[i].ir_pc,
                    tbl[i].v, tbl[i].h, tbl[i].cnt);
        end

        // Top-of-memory behaviour: wrap, or halt on the last address when bounded.
        step(1, 0, 0, 0);
        step(0, 0, 1, 30); chk_all("wrap0", 30, 40'h0,  0,  0, 0, 0);
        step(0, 0, 0, 0);  chk_all("wrap1", 31, 40'd31, 30, 1, 0, 1);
        step(0, 0, 0, 0);
`ifdef FETCH_BOUND_EN
        chk_all("bound2", 31, 40'd32, 31, 1, 0, 2);
        step(0, 0, 0, 0);  chk_all("bound3", 31, 40'd32, 31, 0, 1, 2);
        step(0, 0, 1, 2);  chk_all("bound4", 2,  40'd32, 31, 0, 0, 2);
`else
        chk_all("wrap2", 0, 40'd32, 31, 1, 0, 2);
        step(0, 0, 0, 0);  chk_all("wrap3", 1, 40'h1,  0,  1, 0, 3);
`endif

        // Reset while halted.
        step(1, 0, 0, 0);
        step(0, 0, 1, 6);  chk_all("rh0", 6, 40'h0, 0, 0, 0, 0);
        step(0, 0, 0, 0);  chk_all("rh1", 6, HW,    6, 1, 0, 1);
        step(0, 0, 0, 0);  chk_all("rh2", 6, HW,    6, 0, 1, 1);
        step(1, 0, 0, 0);  chk_all("rh3", 0, 40'h0, 0, 0, 0, 0);

        // Saturation: loop addresses 0..19 with no halt word until the counter pins.
        mem[6] = 40'h7;
        for (int c = 0; c < 69000; c++) begin
            step(0, 0, logic'(pc == 5'd20), 5'd0);
        end
        chk("sat.count", 40'(fetch_count), 40'hFFFF);
        step(0, 0, 0, 0);
        chk("sat.hold", 40'(fetch_count), 40'hFFFF);
        mem[6] = HW;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the PBL core. It owns the program counter, drives the PC into the combinational instruction memory, and latches the returned 40-bit word into an instruction register for the decode/execute stage. It handles stalls, jump redirects with a one-slot flush, and halt detection. It sits between the execute stage, which supplies `stall`/`jump_en`/`jump_addr`, and the instruction memory, which consumes `pc` and returns `instruction`.

## Interface
- `INSTRUCTION_WIDTH`, 40: instruction word width.
- `PC_WIDTH`, 5: program counter width.
- `HALT_OPCODE`, 8'hFF: value of `instruction[INSTRUCTION_WIDTH-1 -: 8]` that halts fetch.
- `PC_LAST`, 5'd31: last valid program address. Used only with `FETCH_BOUND_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc` out PC_WIDTH: registered fetch address to instruction memory.
- `instruction` in INSTRUCTION_WIDTH: word returned combinationally by memory for `pc`.
- `stall` in 1: hold fetch state this cycle.
- `jump_en` in 1: redirect fetch to `jump_addr`.
- `jump_addr` in PC_WIDTH: redirect target.
- `ir` out INSTRUCTION_WIDTH: latched instruction.
- `ir_pc` out PC_WIDTH: address `ir` was fetched from.
- `ir_valid` out 1: `ir` holds a valid instruction to execute.
- `halted` out 1: fetch is in HALT state.
- `fetch_count` out 16: saturating count of instructions latched with `ir_valid=1`.

## Operation
- **Reset values** (on any `rst=1` edge, including mid-operation): `pc=0`, `ir=0`, `ir_pc=0`, `ir_valid=0`, `halted=0`, `fetch_count=0`, state RUN.
- **States:** RUN and HALT.
- **RUN. Priority order is `jump_en`, then `stall`, then normal fetch.**
  - **`jump_en=1`:**
    - `pc<=jump_addr`.
    - `ir_valid<=0`, flushing the wrong-path word.
    - `ir`/`ir_pc` are unchanged.
    - `jump_en` overrides a simultaneous `stall`.
  - **`stall=1`:** `pc`, `ir`, `ir_pc`, `ir_valid`, `fetch_count` all hold.
  - **Normal fetch:**
    - `ir<=instruction`, `ir_pc<=pc`, `ir_valid<=1`.
    - `fetch_count` increments, saturating at 16'hFFFF.
    - `pc<=pc+1` modulo 2^PC_WIDTH, so 31 wraps to 0.
  - **Halt detect during a normal fetch:** if the opcode field equals `HALT_OPCODE`, the word is still latched with `ir_valid<=1` and counted. `pc` holds, and the next state is HALT.
- **HALT:**
  - `halted=1`, `pc` holds, `ir` holds, `ir_valid<=0` from the first HALT cycle onward.
  - `stall` is ignored.
  - `jump_en=1` leaves HALT: `pc<=jump_addr`, `halted<=0`, state RUN, `ir_valid` stays 0.
  - Otherwise HALT persists until reset.
- **Width:** all PC arithmetic is PC_WIDTH bits with natural overflow. No out-of-range addresses exist.

## Timing
- `pc` is registered. `instruction` is valid combinationally in the same cycle. `ir` shows that word one edge later, so fetch latency is 1 cycle.
- A jump asserted in cycle N gives:
  - `pc=jump_addr` after edge N.
  - `ir_valid=0` after edge N.
  - The target instruction in `ir` with `ir_valid=1` after edge N+1, assuming no stall.
  - The jump penalty is one bubble.
- Stall has zero-cycle effect: the edge following `stall=1` changes nothing.
- `halted` rises on the edge after the HALT word is latched into `ir`. That is the same edge on which `ir_valid` goes 0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `FETCH_BOUND_EN`.
- **Defined:** a normal fetch at `pc==PC_LAST` behaves exactly like a HALT opcode. The word is latched and counted, `pc` holds at `PC_LAST`, and the state goes to HALT. A jump to any address is still honoured.
- **Undefined:** `PC_LAST` is ignored, and `pc` wraps from 2^PC_WIDTH-1 to 0 in free-running fashion.

## Test plan
- **Reset then free run:** memory holds 0x01..0x05 at 0..4, no stall or jump.
  - `pc` steps 0,1,2,….
  - `ir` is 0x01 at cycle 1 with `ir_pc=0`, then 0x02, and so on.
  - `fetch_count=5` after 5 fetches.
- **Stall:** assert `stall` for 3 cycles at `pc=2`. `pc` stays 2, and `ir`/`ir_valid`/`fetch_count` are frozen. Fetch resumes at addr 2 afterward.
- **Jump:** `jump_en=1`, `jump_addr=5'd20` while `pc=3`, with `stall=1` in the same cycle.
  - Next cycle: `pc=20`, `ir_valid=0`.
  - Cycle after: `ir=mem[20]`, `ir_pc=20`, `ir_valid=1`.
- **Halt:** `mem[6]` has 0xFF in bits 39:32.
  - `ir=mem[6]` with `ir_valid=1`, then `halted=1`, `ir_valid=0`, `pc=6` held for 10 cycles.
  - Then `jump_en` to 0 restarts fetch with `halted=0`.
- **Wrap vs bound:** run from `pc=30` with no halt words.
  - Without `FETCH_BOUND_EN`: `pc` goes 30,31,0.
  - With it: `ir_pc=31`, `ir_valid=1`, then `halted=1`, `pc=31`.
- **Reset mid-operation:** assert `rst` while in HALT and during a stall. All outputs return to their reset values on the next edge.
